// File: rtl/digit_word_collector.sv
// digit_word_collector: reassembles LSB-first sum digits into words and queues them
// in a 2-entry valid/ready buffer whose head entry drives the registered outputs.
module digit_word_collector #(
    parameter int DIGIT_W = 4,
    parameter int NUM_DIGITS = 3,
    localparam int WORD_W = DIGIT_W * NUM_DIGITS,
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DIGIT_W-1:0] s,
    input  logic              c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_carry,
    output logic              overflow,
    output logic [IDX_W-1:0]  digit_idx
);
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] asm_q, asm_d, head_sum_q, head_sum_d, tail_sum_q, tail_sum_d;
    logic              head_c_q, head_c_d, tail_c_q, tail_c_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              last, push, pop, full_stall;

    assign out_valid = cnt_q != 2'd0;
    assign out_sum   = head_sum_q;
    assign out_carry = head_c_q;
    assign overflow  = ovf_q;
    assign digit_idx = idx_q;

    always_comb begin
        asm_d = asm_q;
        if (in_valid) asm_d[idx_q*DIGIT_W +: DIGIT_W] = s;
        last = idx_q == IDX_W'(NUM_DIGITS - 1);
        push = in_valid && last;
        pop = out_valid && out_ready;
        full_stall = cnt_q == 2'd2 && !pop;
        idx_d = in_valid ? (last ? '0 : idx_q + 1'b1) : idx_q;
        // asm_d already carries s in the top slice, so it is the completed word
        head_sum_d = head_sum_q;
        head_c_d = head_c_q;
        if (pop && cnt_q == 2'd2) begin
            head_sum_d = tail_sum_q;
            head_c_d = tail_c_q;
        end else if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) begin
            head_sum_d = asm_d;
            head_c_d = c;
        end
        tail_sum_d = tail_sum_q;
        tail_c_d = tail_c_q;
        if (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) begin
            tail_sum_d = asm_d;
            tail_c_d = c;
        end
        cnt_d = cnt_q + 2'(push && !full_stall) - 2'(pop);
        ovf_d = ovf_q | (push && full_stall);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            asm_q <= '0;
            head_sum_q <= '0;
            head_c_q <= 1'b0;
            tail_sum_q <= '0;
            tail_c_q <= 1'b0;
            cnt_q <= 2'd0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            idx_q <= '0;
            asm_q <= '0;
            cnt_q <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
            head_sum_q <= head_sum_d;
            head_c_q <= head_c_d;
            tail_sum_q <= tail_sum_d;
            tail_c_q <= tail_c_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: doc/digit_word_collector.md
Name: digit_word_collector

Overview:
- Downstream stage of the 4-bit digit-serial adder.
- Consumes the adder's per-cycle sum digit `s` and carry `c` (LSB digit first) and reassembles NUM_DIGITS digits into one parallel sum word plus final carry.
- Presents completed words through a 2-entry valid/ready output buffer to the consumer (result checker / register file).
- Reports words dropped because the buffer was full.

Parameters:
- DIGIT_W, 4, width of one sum digit.
- NUM_DIGITS, 3, digits per word; word width = DIGIT_W*NUM_DIGITS (12 by default).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear: discards partial word, empties buffer, clears overflow.
- in_valid  input  1  s/c qualify this cycle; aligned with adder outputs.
- s  input  DIGIT_W  sum digit from adder.
- c  input  1  carry out of the current digit from adder.
- out_valid  output  1  head buffer entry valid.
- out_ready  input  1  consumer accepts head entry when out_valid&&out_ready.
- out_sum  output  DIGIT_W*NUM_DIGITS  assembled sum word, digit 0 in bits [DIGIT_W-1:0].
- out_carry  output  1  `c` sampled with the last digit of the word.
- overflow  output  1  sticky: a completed word was dropped.
- digit_idx  output  clog2(NUM_DIGITS)  index of next digit expected (debug/visibility).

Behaviour:
- Reset (rst=1, async): digit_idx=0, assembly register=0, buffer empty, out_valid=0, out_sum=0, out_carry=0, overflow=0. Reset mid-word discards the partial word; the next accepted digit is digit 0.
- Assembly:
  - Each cycle with in_valid=1, s is written into slice digit_idx of the assembly register.
  - digit_idx increments and wraps NUM_DIGITS-1 -> 0.
  - in_valid=0 holds all assembly state (gaps allowed anywhere inside a word).
- Word completion: the cycle digit_idx==NUM_DIGITS-1 and in_valid=1 forms {s, assembly[lower digits]} and carry=c. The word is pushed into the buffer at that same edge.
- Latency:
  - With the buffer empty, out_valid rises the cycle after the last digit is sampled, with out_sum/out_carry valid.
  - Minimum in->out latency: 1 cycle after the final digit.
- Buffer:
  - 2-entry FIFO; out_sum/out_carry are registered outputs of the head entry.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are always permitted, including when full. Count is unchanged; the new word enters behind the surviving entry.
  - Push when full without a simultaneous pop: the word is dropped, overflow<=1 (sticky until rst/clr), buffer contents unchanged.
  - out_valid=0 whenever empty. out_sum/out_carry hold their last value when not valid; do not rely on it.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Clear (clr=1): next edge sets digit_idx=0, empties buffer, overflow=0. clr takes priority over a simultaneous digit or pop; the digit is discarded.
- Throughput: sustains one word per NUM_DIGITS cycles with out_ready tied high, no drops.
- No arithmetic is performed; bits pass through unmodified.

Test Plan:
- Reset then continuous in_valid with digits F,2,D and c=0,0,0, out_ready=1 -> one cycle after the third digit: out_valid=1, out_sum=0xD2F, out_carry=0; digit_idx back to 0.
- Five back-to-back words with digits LSB-first, out_ready=1 -> out_valid pulses every 3 cycles:
  - 0xD2F
  - 0x710
  - 0x994
  - 0xDF0
  - 0xF79
  - all with out_carry=0, overflow=0.
- Word for 0xFFF+0x001 (digits 0,0,0; c=1 on each digit) -> out_sum=0x000, out_carry=1.
- in_valid low for 4 cycles between digit 1 and digit 2 of word 0x994 -> digit_idx holds at 2; out_sum=0x994 emitted 1 cycle after the delayed third digit.
- out_ready=0 while three words complete -> first two words buffered (out_sum=0xD2F held stable), third dropped, overflow=1. Raising out_ready then yields 0xD2F, 0x710; overflow stays 1 until clr.
- Assert rst after digit 1 of a word, release, send digits 4,9,9 -> out_sum=0x994; no stale digit from the aborted word appears.
